spi_rx_channelizer: RTL
=======================

Name: spi_rx_channelizer

Overview:
- Sits directly downstream of the SPI master's receive path. Consumes the raw received frames, one per SPI transfer, and tags each with a channel destination.
- Sign- or zero-extends each frame to the bus width and buffers it in a small FIFO.
- Presents the result as a stream with backpressure to the downstream processing chain.
- Frames are grouped into rounds of N_CHANNELS transfers started by a `start` pulse from the transfer sequencer.

Parameters:
- DATA_WIDTH, 16: SPI frame width in bits.
- OUTPUT_WIDTH, 32: output data width; must be >= DATA_WIDTH.
- N_CHANNELS, 4: frames per round; must be >= 1.
- DEST_BASE, 0: destination of channel 0; channel k is tagged DEST_BASE+k.
- FIFO_DEPTH, 4: output buffer entries; must be a power of two and >= 2.
- TIMEOUT, 1024: maximum idle cycles between frames inside a round.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous reset, active high.
- start, input, 1: one-cycle pulse that begins a round.
- in_data, input, DATA_WIDTH: received SPI frame.
- in_valid, input, 1: frame strobe from the SPI master. There is no ready signal; the SPI master cannot stall.
- signed_mode, input, 1: 1 selects sign extension, 0 selects zero extension. Sampled per frame.
- out_data, output, OUTPUT_WIDTH: extended frame.
- out_dest, output, 8: channel destination tag.
- out_valid, output, 1: output stream valid.
- out_ready, input, 1: output stream ready.
- round_done, output, 1: one-cycle pulse when a round completes.
- overflow, output, 1: one-cycle pulse when a frame is dropped because the FIFO is full.
- round_error, output, 1: one-cycle pulse on an aborted or timed-out round, or on a stray frame.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, channel counter 0, timeout counter 0. Reset mid-round discards any FIFO contents.

State machine:
- IDLE:
  - `start` -> COLLECT, channel counter = 0, timeout counter = 0.
  - `in_valid` without `start` -> frame discarded, round_error pulses.
- COLLECT, on `in_valid`:
  - The frame is extended and written to the FIFO with dest = DEST_BASE + channel.
  - The channel counter increments and the timeout counter clears.
  - If channel == N_CHANNELS-1: go to IDLE, and round_done pulses the next cycle.
- COLLECT, with neither `in_valid` nor `start`: the timeout counter increments.
  - On reaching TIMEOUT-1 -> IDLE, round_error pulses the next cycle.
- COLLECT with `start`, including the same cycle as `in_valid`:
  - The round restarts: channel = 0, timeout = 0.
  - Any concurrent frame is discarded.
  - round_error pulses the next cycle.
  - Frames already in the FIFO are kept.
- `start` and `in_valid` in the same cycle in IDLE: `start` wins, the frame is discarded, and no error is flagged.

Extension:
- Signed: bit DATA_WIDTH-1 is replicated into the upper bits.
- Unsigned: the upper bits are zero.
- When OUTPUT_WIDTH == DATA_WIDTH the data passes through unchanged.
- out_dest is 8 bits; the addition wraps modulo 256.

FIFO:
- First-word latency: a frame accepted in cycle t appears on out_valid/out_data/out_dest in cycle t+1 when the FIFO was empty.
- Pop happens when out_valid && out_ready.
- While out_valid is high and out_ready is low, out_data and out_dest hold stable.
- Full FIFO with push and no pop: the frame is dropped and overflow pulses the next cycle. The channel counter still advances, so tags stay aligned with SPI transfers.
- Full FIFO with simultaneous push and pop: the push is accepted, with no overflow.
- Empty FIFO with push: the frame is not combinationally bypassed to the output.
- Occupancy counter width is log2(FIFO_DEPTH)+1; read and write pointers wrap modulo FIFO_DEPTH.

Pulses:
- round_done, overflow and round_error are each exactly one cycle and registered.
- Two events of the same kind in consecutive cycles produce two separate pulses.

Test Plan:
1. Reset released, then `start`, then 4 frames 0x1234, 0x8001, 0x7FFF, 0xFFFF with signed_mode=1 and out_ready=1.
   -> Outputs 0x00001234/0, 0xFFFF8001/1, 0x00007FFF/2, 0xFFFFFFFF/3, each one cycle after input; round_done pulses once after the 4th frame.
2. Same frames with signed_mode=0.
   -> Outputs 0x00008001 and 0x0000FFFF, all upper bits zero.
3. out_ready=0, `start`, then 6 frames (two rounds with a second `start`).
   -> First 4 stored; frames 5 and 6 each produce an overflow pulse; after out_ready=1, exactly 4 words drain with dest 0..3, then out_valid=0.
4. `start`, 2 frames, then 1024 idle cycles.
   -> round_error pulses once; state IDLE; a subsequent frame without `start` produces a second round_error and no output.
5. `start`, 2 frames, then `start` coincident with a frame, then 4 frames.
   -> round_error pulses once; coincident frame absent; outputs tagged 0,1 then 0,1,2,3; one round_done.
6. Assert reset while the FIFO holds 3 words and a round is mid-way.
   -> All outputs 0 immediately (asynchronous); after release, no stale words appear; a new round starts at dest 0.

Source files
------------

// File: rtl/spi_rx_channelizer.sv
// rtl/spi_rx_channelizer.sv - tags SPI receive frames with channel destinations and buffers them as a stream
// Rounds of N_CHANNELS frames are opened by start; frames are extended, tagged and queued in a small FIFO.
module spi_rx_channelizer #(
  parameter int DATA_WIDTH   = 16,
  parameter int OUTPUT_WIDTH = 32,
  parameter int N_CHANNELS   = 4,
  parameter int DEST_BASE    = 0,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  input  logic                    in_valid_i,
  input  logic                    signed_mode_i,
  output logic [OUTPUT_WIDTH-1:0] out_data_o,
  output logic [7:0]              out_dest_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    round_done_o,
  output logic                    overflow_o,
  output logic                    round_error_o
);

  localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CH  = CW'(N_CHANNELS - 1);
  localparam logic [TW-1:0] LAST_TMO = TW'(TIMEOUT - 1);
  localparam logic [7:0]    BASE8    = 8'(DEST_BASE);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state_q;
  logic [CW-1:0]   ch_q;
  logic [TW-1:0]   tmo_q;
  logic            round_done_q;
  logic            round_error_q;
  logic            overflow_q;

  logic [OUTPUT_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [7:0]              dest_mem [FIFO_DEPTH];
  logic [PW-1:0]           rd_q, wr_q;
  logic [PW:0]             count_q, count_d;

  logic                    accept, pop, full, wr_en, overflow_d;
  logic [OUTPUT_WIDTH-1:0] ext_data;
  logic [7:0]              ext_dest;

  always_comb begin
    ext_data = '0;
    ext_data[DATA_WIDTH-1:0] = in_data_i;
    for (int i = DATA_WIDTH; i < OUTPUT_WIDTH; i++) begin
      ext_data[i] = signed_mode_i & in_data_i[DATA_WIDTH-1];
    end
  end

  // A frame landing on a restart is dropped, so only start-free frames count as accepted.
  assign accept     = (state_q == COLLECT) && in_valid_i && !start_i;
  assign ext_dest   = BASE8 + 8'(ch_q);
  assign pop        = (count_q != '0) && out_ready_i;
  assign full       = (count_q == (PW+1)'(FIFO_DEPTH));
  assign wr_en      = accept && (!full || pop);
  assign overflow_d = accept && full && !pop;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !wr_en) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      tmo_q         <= '0;
      round_done_q  <= 1'b0;
      round_error_q <= 1'b0;
    end else begin
      round_done_q  <= 1'b0;
      round_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= COLLECT;
            ch_q    <= '0;
            tmo_q   <= '0;
          end else if (in_valid_i) begin
            round_error_q <= 1'b1;
          end
        end
        COLLECT: begin
          if (start_i) begin
            ch_q          <= '0;
            tmo_q         <= '0;
            round_error_q <= 1'b1;
          end else if (in_valid_i) begin
            tmo_q <= '0;
            if (ch_q == LAST_CH) begin
              state_q      <= IDLE;
              ch_q         <= '0;
              round_done_q <= 1'b1;
            end else begin
              ch_q <= ch_q + 1'b1;
            end
          end else if (tmo_q == LAST_TMO) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            tmo_q         <= '0;
            round_error_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      count_q    <= count_d;
      if (wr_en) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      data_mem[wr_q] <= ext_data;
      dest_mem[wr_q] <= ext_dest;
    end
  end

  // Storage is not reset, so the head entry is masked while the FIFO is empty.
  assign out_valid_o   = (count_q != '0);
  assign out_data_o    = out_valid_o ? data_mem[rd_q] : '0;
  assign out_dest_o    = out_valid_o ? dest_mem[rd_q] : '0;
  assign round_done_o  = round_done_q;
  assign overflow_o    = overflow_q;
  assign round_error_o = round_error_q;

endmodule
